// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: access sizes and FSM states.
// Optional misaligned-access exception is enabled by defining MAU_MISALIGN_EXC_EN.
package mau_pkg;

    localparam logic [1:0] MAU_SZ_BYTE = 2'b00;
    localparam logic [1:0] MAU_SZ_HALF = 2'b01;
    localparam logic [1:0] MAU_SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } mau_state_t;

    // Size codes 10 and 11 both mean a full word.
    function automatic logic isWord(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Little-endian lane steering: extract/extend for loads and merge for sub-word stores.
// Purely combinational; shared by both build variants (MAU_MISALIGN_EXC_EN on or off).
module mau_lane
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Half accesses only look at off_i[1]; the low bit is truncated here.
    always_comb begin
        byteSel = word_i[{off_i, 3'b000} +: 8];
        halfSel = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        merge_o = data_i;
        if (size_i == MAU_SZ_BYTE) begin
            load_o  = {{24{byteSel[7] & ~uns_i}}, byteSel};
            merge_o = word_i;
            merge_o[{off_i, 3'b000} +: 8] = data_i[7:0];
        end else if (size_i == MAU_SZ_HALF) begin
            load_o  = {{16{halfSel[15] & ~uns_i}}, halfSel};
            merge_o = off_i[1] ? {data_i[15:0], word_i[15:0]}
                               : {word_i[31:16], data_i[15:0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle byte/half/word load-store initiator on a 128-word memory port.
// Define MAU_MISALIGN_EXC_EN to trap misaligned half/word accesses instead of truncating.
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [6:0]  dm_addr,
    output logic        dm_we,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    mau_state_t  state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] din_q;
    logic [6:0]  addr_q;
    logic        misal_q;
    logic        misalignHit;
    logic [31:0] loadWord;
    logic [31:0] mergeWord;
    logic        unusedAddr;

    assign unusedAddr = ^addr[31:9];

`ifdef MAU_MISALIGN_EXC_EN
    assign misalignHit = ((size == MAU_SZ_HALF) && addr[0]) ||
                         (isWord(size) && (addr[1:0] != 2'b00));
`else
    assign misalignHit = 1'b0;
`endif

    mau_lane u_lane (
        .word_i  (dm_dout),
        .data_i  (wdata_q),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .load_o  (loadWord),
        .merge_o (mergeWord)
    );

    // Word stores skip the read phase; everything else reads the target word first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= MAU_SZ_BYTE;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            wdata_q <= '0;
            rdata_q <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            misal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        off_q   <= addr[1:0];
                        wdata_q <= wdata;
                        addr_q  <= addr[8:2];
                        misal_q <= misalignHit;
                        if (misalignHit) begin
                            state_q <= ST_RESP;
                        end else if (we && isWord(size)) begin
                            din_q   <= wdata;
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (we_q) begin
                        din_q   <= mergeWord;
                        state_q <= ST_WR;
                    end else begin
                        rdata_q <= loadWord;
                        state_q <= ST_RESP;
                    end
                end
                ST_WR:   state_q <= ST_RESP;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = (state_q == ST_RESP);
    assign dm_we    = (state_q == ST_WR);
    assign misalign = done & misal_q;
    assign rdata    = rdata_q;
    assign dm_addr  = addr_q;
    assign dm_din   = din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word-array memory and a reference model.
// Expectations follow MAU_MISALIGN_EXC_EN when it is defined for the build.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic [6:0]  dm_addr;
    logic        dm_we;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    logic [31:0] mem    [0:127];
    logic [31:0] refMem [0:127];
    logic [31:0] refRdata;
    int          checks;
    int          errors;

    mem_access_unit dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .uns      (uns),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .rdata    (rdata),
        .misalign (misalign),
        .dm_addr  (dm_addr),
        .dm_we    (dm_we),
        .dm_din   (dm_din),
        .dm_dout  (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_din;
    end

    function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic un);
        int unsigned v;
        int unsigned sh;
        if (sz == 2'd0) begin
            sh = a[1:0];
            v  = (w >> (sh * 8)) & 32'hFF;
            if (!un && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            sh = a[1];
            v  = (w >> (sh * 16)) & 32'hFFFF;
            if (!un && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] old, input logic [31:0] d,
                                             input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] mask;
        int unsigned sh;
        if (sz == 2'd0) begin
            mask = 32'hFF;
            sh   = a[1:0];
            sh   = sh * 8;
        end else if (sz == 2'd1) begin
            mask = 32'hFFFF;
            sh   = a[1];
            sh   = sh * 16;
        end else begin
            mask = 32'hFFFFFFFF;
            sh   = 0;
        end
        return (old & ~(mask << sh)) | ((d & mask) << sh);
    endfunction

    function automatic logic refMisaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef MAU_MISALIGN_EXC_EN
        return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'd0));
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One complete request: model update, drive, count cycles to done, check results.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic un,
                                 input logic [31:0] a, input logic [31:0] d, input string tag);
        int   idx;
        int   lat;
        int   cyc;
        int   weCnt;
        logic mis;
        idx = a[8:2];
        mis = refMisaligned(a, sz);
        lat = mis ? 1 : ((!w || sz >= 2'd2) ? 2 : 3);
        if (!mis) begin
            if (w) refMem[idx] = refStore(refMem[idx], d, a, sz);
            else   refRdata    = refLoad(refMem[idx], a, sz, un);
        end
        @(negedge clk);
        checkOutput({tag, ".ready"}, 32'(ready), 32'd1);
        we = w; size = sz; uns = un; addr = a; wdata = d; req = 1'b1;
        cyc = 0;
        weCnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req = 1'b0;
            if (dm_we) weCnt++;
            if (done) break;
        end
        checkOutput({tag, ".latency"}, 32'(cyc), 32'(lat));
        checkOutput({tag, ".weCount"}, 32'(weCnt), (mis || !w) ? 32'd0 : 32'd1);
        checkOutput({tag, ".misalign"}, 32'(misalign), 32'(mis));
        checkOutput({tag, ".rdata"}, rdata, refRdata);
        checkOutput({tag, ".mem"}, mem[idx], refMem[idx]);
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] firstWord;
        logic [31:0] secondWord;
        int          doneSeen;
        checks = 0;
        errors = 0;
        refRdata = 32'd0;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 128; i++) refMem[i] = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("rst.ready", 32'(ready), 32'd1);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.misalign", 32'(misalign), 32'd0);
        checkOutput("rst.dmWe", 32'(dm_we), 32'd0);
        checkOutput("rst.rdata", rdata, 32'd0);
        checkOutput("rst.dmDin", dm_din, 32'd0);
        checkOutput("rst.dmAddr", 32'(dm_addr), 32'd0);
        rst = 1'b0;

        $display("[TB] preloading memory through word stores");
        for (int i = 0; i < 128; i++) applyStimulus(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "preload");

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, "wordSt");
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, "wordLd");
        checkOutput("wordLd.const", rdata, 32'hDEADBEEF);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h010, 32'h11223344, "seedByte");
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h013, 32'h000000AB, "byteSt");
        checkOutput("byteSt.const", mem[4], 32'hAB223344);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h010, 32'h80FF0000, "seedExt");
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h013, 32'h0, "byteLdS");
        checkOutput("byteLdS.const", rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h013, 32'h0, "byteLdU");
        checkOutput("byteLdU.const", rdata, 32'h00000080);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h012, 32'h0, "halfLdS");
        checkOutput("halfLdS.const", rdata, 32'hFFFF80FF);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h012, 32'h0, "halfLdU");
        checkOutput("halfLdU.const", rdata, 32'h000080FF);

        applyStimulus(1'b0, 2'd1, 1'b0, 32'h011, 32'h0, "halfOdd");
`ifdef MAU_MISALIGN_EXC_EN
        checkOutput("halfOdd.const", rdata, 32'h000080FF);
`else
        checkOutput("halfOdd.const", rdata, 32'h00000000);
`endif

        $display("[TB] reset during write phase");
        @(negedge clk);
        we = 1'b1; size = 2'd1; uns = 1'b0; addr = 32'h012; wdata = 32'h00005555; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checkOutput("rstWr.weBefore", 32'(dm_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstWr.weDrop", 32'(dm_we), 32'd0);
        checkOutput("rstWr.done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        refRdata = 32'd0;
        #1;
        checkOutput("rstWr.ready", 32'(ready), 32'd1);
        checkOutput("rstWr.mem", mem[4], 32'h80FF0000);
        checkOutput("rstWr.rdata", rdata, refRdata);
        doneSeen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("rstWr.noDone", 32'(doneSeen), 32'd0);

        $display("[TB] back-to-back loads with req held high");
        firstWord  = refMem[8];
        secondWord = refMem[9];
        @(negedge clk);
        we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h020; req = 1'b1;
        @(negedge clk);
        addr = 32'h024;
        checkOutput("hold.c1Ready", 32'(ready), 32'd0);
        @(negedge clk);
        checkOutput("hold.c2Done", 32'(done), 32'd1);
        checkOutput("hold.c2Rdata", rdata, firstWord);
        @(negedge clk);
        checkOutput("hold.c3Ready", 32'(ready), 32'd1);
        checkOutput("hold.c3Done", 32'(done), 32'd0);
        @(negedge clk);
        req = 1'b0;
        checkOutput("hold.c4Ready", 32'(ready), 32'd0);
        checkOutput("hold.c4Rdata", rdata, firstWord);
        @(negedge clk);
        checkOutput("hold.c5Done", 32'(done), 32'd1);
        checkOutput("hold.c5Rdata", rdata, secondWord);
        refRdata = secondWord;
        @(negedge clk);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                          $urandom, $urandom, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
